// File: rtl/map_rom_arbiter.sv
// Map ROM arbiter: shares one single-port map ROM between the VGA pixel fetch
// path (absolute priority) and two game-logic clients served round-robin.
// Read data returns tagged, with a fixed ROM_LAT+2 cycle latency for everyone.
module map_rom_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int ROM_LAT    = 0,
    parameter int STARVE_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vga_req,
    input  logic [ADDR_W-1:0]     vga_addr,
    output logic                  vga_rvalid,
    output logic [DATA_W-1:0]     vga_rdata,
    input  logic [1:0]            cli_req,
    input  logic [2*ADDR_W-1:0]   cli_addr,
    output logic [1:0]            cli_gnt,
    output logic [1:0]            cli_rvalid,
    output logic [DATA_W-1:0]     cli_rdata,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [1:0]            starve,
    output logic                  busy
);

    localparam logic [1:0]  TAG_NONE   = 2'd0;
    localparam logic [1:0]  TAG_VGA    = 2'd1;
    localparam logic [1:0]  TAG_CLI0   = 2'd2;
    localparam logic [1:0]  TAG_CLI1   = 2'd3;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;
    localparam logic [15:0] STARVE_LIM = 16'(STARVE_MAX);

    // Saturating increment for the starvation wait counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    // rr_ptr names the client that wins when both clients request together.
    logic              rr_ptr;
    logic [1:0]        win_tag;
    logic [ADDR_W-1:0] win_addr;
    // tag_pipe[0] holds the owner of the address now on rom_addr; the owner
    // reaches tag_pipe[ROM_LAT] in the cycle its rom_data is valid.
    logic [1:0]        tag_pipe [0:ROM_LAT];
    logic [15:0]       wait_cnt [2];
    logic [15:0]       wait_nxt [2];

    // Pick this cycle's ROM owner: VGA first, then clients by round-robin.
    always_comb begin
        win_tag  = TAG_NONE;
        win_addr = rom_addr;
        cli_gnt  = 2'b00;
        if (!rst) begin
            if (vga_req) begin
                win_tag  = TAG_VGA;
                win_addr = vga_addr;
            end else if (cli_req[0] && (!cli_req[1] || !rr_ptr)) begin
                win_tag  = TAG_CLI0;
                win_addr = cli_addr[0 +: ADDR_W];
                cli_gnt  = 2'b01;
            end else if (cli_req[1]) begin
                win_tag  = TAG_CLI1;
                win_addr = cli_addr[ADDR_W +: ADDR_W];
                cli_gnt  = 2'b10;
            end
        end
    end

    // Round-robin pointer moves to the other client after each client grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (cli_gnt[0]) begin
            rr_ptr <= 1'b1;
        end else if (cli_gnt[1]) begin
            rr_ptr <= 1'b0;
        end
    end

    // Issue stage: register the winning address and shift the owner tag along.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= TAG_NONE;
            end
        end else begin
            rom_addr    <= win_addr;
            tag_pipe[0] <= win_tag;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // Capture stage: steer rom_data to its owner with a one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rvalid <= 1'b0;
            cli_rvalid <= 2'b00;
            vga_rdata  <= '0;
            cli_rdata  <= '0;
        end else begin
            vga_rvalid <= (tag_pipe[ROM_LAT] == TAG_VGA);
            cli_rvalid <= {(tag_pipe[ROM_LAT] == TAG_CLI1),
                           (tag_pipe[ROM_LAT] == TAG_CLI0)};
            if (tag_pipe[ROM_LAT] == TAG_VGA) begin
                vga_rdata <= rom_data;
            end
            if ((tag_pipe[ROM_LAT] == TAG_CLI0) || (tag_pipe[ROM_LAT] == TAG_CLI1)) begin
                cli_rdata <= rom_data;
            end
        end
    end

    // Busy while any read sits in the tag pipeline or its rvalid is showing.
    always_comb begin
        busy = vga_rvalid | (|cli_rvalid);
        for (int k = 0; k <= ROM_LAT; k++) begin
            busy = busy | (tag_pipe[k] != TAG_NONE);
        end
    end

    // Next wait count: clears on grant or idle, otherwise counts up saturating.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wait_nxt[i] = (!cli_req[i] || cli_gnt[i]) ? 16'd0 : sat_inc(wait_cnt[i]);
        end
    end

    // Wait counters and registered starvation flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wait_cnt[i] <= 16'd0;
            end
            starve <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wait_cnt[i] <= wait_nxt[i];
                starve[i]   <= (wait_nxt[i] >= STARVE_LIM);
            end
        end
    end

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Bench for map_rom_arbiter: two instances (ROM_LAT 0 and 2) share one stimulus
// stream and are compared every cycle against a transaction-level model that
// keeps a queue of expected responses with their due cycle.
module tb_map_rom_arbiter;

    localparam int SMAX = 8;

    typedef struct {
        int          due;
        int          owner;   // 0 = VGA, 1 = client 0, 2 = client 1
        logic [11:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_req = 1'b0;
    logic [15:0] vga_addr = '0;
    logic [1:0]  cli_req = '0;
    logic [31:0] cli_addr = '0;

    logic [1:0]       vga_rvalid_o;
    logic [1:0][11:0] vga_rdata_o;
    logic [1:0][1:0]  cli_gnt_o;
    logic [1:0][1:0]  cli_rvalid_o;
    logic [1:0][11:0] cli_rdata_o;
    logic [1:0][15:0] rom_addr_o;
    logic [1:0][1:0]  starve_o;
    logic [1:0]       busy_o;
    logic [11:0]      rom_data0;
    logic [11:0]      rom_data2;
    logic [11:0]      rom_r1;
    logic [11:0]      rom_r2;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat_m [2] = '{0, 2};
    bit          ptr_m;
    int          wait_m [2];
    bit [1:0]    starve_m;
    logic [15:0] rom_addr_m;
    logic [11:0] vga_last [2];
    logic [11:0] cli_last [2];
    resp_t       rq [2][$];
    logic [1:0]  last_gnt = '0;
    logic [1:0]  prev_req = '0;
    logic [31:0] prev_addr = '0;
    bit          prev_r = 1'b1;

    always #5 clk = ~clk;

    // ROM contents: data = addr[11:0]; latency 0 is combinational, 2 is two registers.
    assign rom_data0 = rom_addr_o[0][11:0];
    always @(posedge clk) begin
        rom_r1 <= rom_addr_o[1][11:0];
        rom_r2 <= rom_r1;
    end
    assign rom_data2 = rom_r2;

    map_rom_arbiter #(.ADDR_W(16), .DATA_W(12), .ROM_LAT(0), .STARVE_MAX(SMAX)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_rvalid(vga_rvalid_o[0]), .vga_rdata(vga_rdata_o[0]),
        .cli_req(cli_req), .cli_addr(cli_addr),
        .cli_gnt(cli_gnt_o[0]), .cli_rvalid(cli_rvalid_o[0]), .cli_rdata(cli_rdata_o[0]),
        .rom_addr(rom_addr_o[0]), .rom_data(rom_data0),
        .starve(starve_o[0]), .busy(busy_o[0])
    );

    map_rom_arbiter #(.ADDR_W(16), .DATA_W(12), .ROM_LAT(2), .STARVE_MAX(SMAX)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_rvalid(vga_rvalid_o[1]), .vga_rdata(vga_rdata_o[1]),
        .cli_req(cli_req), .cli_addr(cli_addr),
        .cli_gnt(cli_gnt_o[1]), .cli_rvalid(cli_rvalid_o[1]), .cli_rdata(cli_rdata_o[1]),
        .rom_addr(rom_addr_o[1]), .rom_data(rom_data2),
        .starve(starve_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        ptr_m      = 1'b0;
        starve_m   = 2'b00;
        rom_addr_m = '0;
        for (int d = 0; d < 2; d++) begin
            wait_m[d]   = 0;
            vga_last[d] = '0;
            cli_last[d] = '0;
            rq[d].delete();
        end
    endtask

    // One clock cycle: drive inputs, check every output against the model,
    // then advance the model across the coming clock edge.
    task automatic step(input bit r, input bit v, input logic [15:0] va,
                        input logic [1:0] cr, input logic [15:0] a0, input logic [15:0] a1);
        int          win;
        logic [15:0] waddr;
        logic [1:0]  egnt;
        @(posedge clk);
        #1;
        rst      = r;
        vga_req  = v;
        vga_addr = va;
        cli_req  = cr;
        cli_addr = {a1, a0};
        #1;
        cyc++;

        // Who owns the ROM this cycle.
        win   = -1;
        waddr = '0;
        egnt  = 2'b00;
        if (!r) begin
            if (v) begin
                win = 0; waddr = va;
            end else if (cr == 2'b01) begin
                win = 1;
            end else if (cr == 2'b10) begin
                win = 2;
            end else if (cr == 2'b11) begin
                win = ptr_m ? 2 : 1;
            end
            if (win == 1) begin waddr = a0; egnt = 2'b01; end
            if (win == 2) begin waddr = a1; egnt = 2'b10; end
        end

        // A client held without grant must keep its address.
        if (!prev_r && !r) begin
            for (int i = 0; i < 2; i++) begin
                if (prev_req[i] && !last_gnt[i] && cr[i]) begin
                    chk($sformatf("addr_hold c%0d", i), 32'(cli_addr[i*16 +: 16]),
                        32'(prev_addr[i*16 +: 16]));
                end
            end
        end

        for (int d = 0; d < 2; d++) begin
            logic       evr;
            logic [1:0] ecr;
            while (rq[d].size() > 0 && rq[d][0].due < cyc) void'(rq[d].pop_front());
            evr = 1'b0;
            ecr = 2'b00;
            if (rq[d].size() > 0 && rq[d][0].due == cyc) begin
                case (rq[d][0].owner)
                    0: begin evr = 1'b1;    vga_last[d] = rq[d][0].data; end
                    1: begin ecr = 2'b01;   cli_last[d] = rq[d][0].data; end
                    default: begin ecr = 2'b10; cli_last[d] = rq[d][0].data; end
                endcase
            end
            chk($sformatf("L%0d cli_gnt", lat_m[d]),    32'(cli_gnt_o[d]),    32'(egnt));
            chk($sformatf("L%0d vga_rvalid", lat_m[d]), 32'(vga_rvalid_o[d]), 32'(evr));
            chk($sformatf("L%0d cli_rvalid", lat_m[d]), 32'(cli_rvalid_o[d]), 32'(ecr));
            chk($sformatf("L%0d vga_rdata", lat_m[d]),  32'(vga_rdata_o[d]),  32'(vga_last[d]));
            chk($sformatf("L%0d cli_rdata", lat_m[d]),  32'(cli_rdata_o[d]),  32'(cli_last[d]));
            chk($sformatf("L%0d busy", lat_m[d]),       32'(busy_o[d]),       32'(rq[d].size() > 0));
            chk($sformatf("L%0d starve", lat_m[d]),     32'(starve_o[d]),     32'(starve_m));
            chk($sformatf("L%0d rom_addr", lat_m[d]),   32'(rom_addr_o[d]),   32'(rom_addr_m));
        end

        // Advance the model across the edge that ends this cycle.
        if (r) begin
            model_reset();
        end else begin
            if (win >= 0) begin
                resp_t e;
                rom_addr_m = waddr;
                for (int d = 0; d < 2; d++) begin
                    e.due   = cyc + lat_m[d] + 2;
                    e.owner = win;
                    e.data  = waddr[11:0];
                    rq[d].push_back(e);
                end
                if (win == 1) ptr_m = 1'b1;
                if (win == 2) ptr_m = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!cr[i] || egnt[i]) wait_m[i] = 0;
                else if (wait_m[i] < 65535) wait_m[i]++;
                starve_m[i] = (wait_m[i] >= SMAX);
            end
        end
        last_gnt  = egnt;
        prev_req  = cr;
        prev_addr = {a1, a0};
        prev_r    = r;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  rs;
        logic [15:0] ad [2];
        bit          v;
        bit          r;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // VGA burst 0x0010..0x0013.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 16'h0010 + 16'(k), 2'b00, 16'h0, 16'h0);
        idle(4);

        // Both clients contending: grants alternate starting with client 0.
        repeat (4) step(1'b0, 1'b0, 16'h0, 2'b11, 16'h0100, 16'h0200);
        idle(4);

        // VGA saturates the ROM while client 0 waits, then VGA drops.
        repeat (10) step(1'b0, 1'b1, 16'h0020, 2'b01, 16'h0ABC, 16'h0);
        step(1'b0, 1'b0, 16'h0, 2'b01, 16'h0ABC, 16'h0);
        idle(3);

        // Interleaved VGA / client 1.
        step(1'b0, 1'b1, 16'h0030, 2'b10, 16'h0, 16'h0311);
        step(1'b0, 1'b0, 16'h0,    2'b10, 16'h0, 16'h0311);
        step(1'b0, 1'b1, 16'h0031, 2'b10, 16'h0, 16'h0322);
        step(1'b0, 1'b0, 16'h0,    2'b10, 16'h0, 16'h0322);
        idle(6);

        // Reset with reads in flight; pointer must restart at client 0.
        step(1'b0, 1'b0, 16'h0,    2'b01, 16'h0444, 16'h0);
        step(1'b0, 1'b1, 16'h0555, 2'b00, 16'h0,    16'h0);
        step(1'b1, 1'b0, 16'h0,    2'b00, 16'h0,    16'h0);
        idle(6);
        step(1'b0, 1'b0, 16'h0,    2'b11, 16'h0100, 16'h0200);
        idle(4);

        // Single uncontended client 1 request.
        step(1'b0, 1'b0, 16'h0, 2'b10, 16'h0, 16'h0777);
        idle(5);

        // Randomized traffic honouring the hold-until-granted protocol.
        rs = 2'b00;
        ad[0] = '0;
        ad[1] = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (rs[i]) begin
                    if (last_gnt[i]) begin
                        if ($urandom_range(1, 0) == 1) ad[i] = 16'($urandom);
                        else rs[i] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    rs[i] = 1'b1;
                    ad[i] = 16'($urandom);
                end
            end
            v = (n < 300) ? ($urandom_range(1, 0) == 1) : ($urandom_range(9, 0) != 0);
            r = ($urandom_range(79, 0) == 0);
            step(r, v, 16'($urandom), rs, ad[0], ad[1]);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
